// File: rtl/vga_pkg.sv
// Resolution math and FSM state encoding shared by the VGA address translator and decoder.
package vga_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_DIV  = 2'd1,
    ST_DONE = 2'd2
  } vga_state_e;

  // 4:3 modes: 160x120, 320x240, 640x480 for nY = 7, 8, 9.
  function automatic int unsigned vga_width(input int unsigned ny);
    return (32'd1 << ny) + (32'd1 << (ny - 32'd2));
  endfunction

  function automatic int unsigned vga_height(input int unsigned ny);
    return (32'd3 * vga_width(ny)) / 32'd4;
  endfunction

  function automatic int unsigned vga_npix(input int unsigned ny);
    return vga_width(ny) * vga_height(ny);
  endfunction

endpackage

// File: rtl/vga_div_step.sv
// One restoring-division step: subtract WIDTH << idx from the partial remainder when it fits.
module vga_div_step
  import vga_pkg::*;
#(
  parameter int nY = 8,
  parameter int Mn = 17,
  parameter int IW = 3
) (
  input  logic [Mn:0]   rem_i,
  input  logic [IW-1:0] idx_i,
  output logic [Mn:0]   rem_o,
  output logic          q_o
);

  localparam int unsigned WIDTH     = vga_width(nY);
  localparam logic [Mn:0] WIDTH_EXT = WIDTH[Mn:0];

  logic [Mn:0] div_w;

  always_comb begin
    div_w = WIDTH_EXT << idx_i;
    q_o   = (rem_i >= div_w);
    rem_o = q_o ? (rem_i - div_w) : rem_i;
  end

endmodule

// File: rtl/vga_address_decoder.sv
// Linear framebuffer address -> (x, y) using a bit-serial restoring divider by WIDTH.
//
// state   | meaning
// IDLE    | ready for a request (in_ready = 1)
// DIV     | nY divide steps, MSB quotient bit first
// DONE    | result/err held until out_ready
module vga_address_decoder
  import vga_pkg::*;
#(
  parameter int nX = 9,
  parameter int nY = 8,
  parameter int Mn = 17
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [Mn-1:0] address,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [nX-1:0] x,
  output logic [nY-1:0] y,
  output logic          err
);

  localparam int unsigned NPIX     = vga_npix(nY);
  localparam logic [Mn:0] NPIX_EXT = NPIX[Mn:0];
  localparam int          IW       = (nY > 1) ? $clog2(nY) : 1;
  localparam logic [IW-1:0] IDX_TOP = IW'(nY - 1);
  localparam logic [IW-1:0] IDX_ONE = IW'(1);

  vga_state_e    state_q, state_d;
  logic [Mn:0]   rem_q, rem_d;
  logic [nY-1:0] quo_q, quo_d;
  logic [IW-1:0] idx_q, idx_d;
  logic [nX-1:0] x_q, x_d;
  logic [nY-1:0] y_q, y_d;
  logic          err_q, err_d;

  logic [Mn:0]   rem_nx;
  logic          q_bit;
  logic [nY-1:0] quo_step;

  vga_div_step #(
    .nY (nY),
    .Mn (Mn),
    .IW (IW)
  ) u_step (
    .rem_i (rem_q),
    .idx_i (idx_q),
    .rem_o (rem_nx),
    .q_o   (q_bit)
  );

  // in_ready is gated by reset so it reads 0 for the whole time reset is held.
  assign in_ready  = (state_q == ST_IDLE) && !reset;
  assign out_valid = (state_q == ST_DONE);
  assign x         = x_q;
  assign y         = y_q;
  assign err       = err_q;

  always_comb begin
    state_d  = state_q;
    rem_d    = rem_q;
    quo_d    = quo_q;
    idx_d    = idx_q;
    x_d      = x_q;
    y_d      = y_q;
    err_d    = err_q;
    quo_step = quo_q;
    quo_step[idx_q] = q_bit;

    case (state_q)
      ST_IDLE: begin
        if (in_valid && in_ready) begin
          if ({1'b0, address} >= NPIX_EXT) begin
            err_d   = 1'b1;
            x_d     = '0;
            y_d     = '0;
            state_d = ST_DONE;
          end else begin
            err_d   = 1'b0;
            rem_d   = {1'b0, address};
            quo_d   = '0;
            idx_d   = IDX_TOP;
            state_d = ST_DIV;
          end
        end
      end
      ST_DIV: begin
        rem_d = rem_nx;
        quo_d = quo_step;
        if (idx_q == '0) begin
          // Address < NPIX guarantees the final remainder is below WIDTH.
          x_d     = rem_nx[nX-1:0];
          y_d     = quo_step;
          state_d = ST_DONE;
        end else begin
          idx_d = idx_q - IDX_ONE;
        end
      end
      ST_DONE: begin
        if (out_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      rem_q   <= '0;
      quo_q   <= '0;
      idx_q   <= '0;
      x_q     <= '0;
      y_q     <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      rem_q   <= rem_d;
      quo_q   <= quo_d;
      idx_q   <= idx_d;
      x_q     <= x_d;
      y_q     <= y_d;
      err_q   <= err_d;
    end
  end

endmodule

// File: tb/tb_vga_address_decoder.sv
// Randomized and directed checks of the address decoder at 160x120, 320x240 and 640x480.
module tb_vga_address_decoder;

  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  logic [2:0] iv, ir, ov, ordy, er;
  logic [16:0] a0;
  logic [14:0] a1;
  logic [18:0] a2;
  logic [8:0]  x0;
  logic [7:0]  x1;
  logic [9:0]  x2;
  logic [7:0]  y0;
  logic [6:0]  y1;
  logic [8:0]  y2;

  vga_address_decoder #(.nX(9), .nY(8), .Mn(17)) u_dut0 (
    .clock(clock), .reset(reset), .in_valid(iv[0]), .in_ready(ir[0]), .address(a0),
    .out_valid(ov[0]), .out_ready(ordy[0]), .x(x0), .y(y0), .err(er[0]));
  vga_address_decoder #(.nX(8), .nY(7), .Mn(15)) u_dut1 (
    .clock(clock), .reset(reset), .in_valid(iv[1]), .in_ready(ir[1]), .address(a1),
    .out_valid(ov[1]), .out_ready(ordy[1]), .x(x1), .y(y1), .err(er[1]));
  vga_address_decoder #(.nX(10), .nY(9), .Mn(19)) u_dut2 (
    .clock(clock), .reset(reset), .in_valid(iv[2]), .in_ready(ir[2]), .address(a2),
    .out_valid(ov[2]), .out_ready(ordy[2]), .x(x2), .y(y2), .err(er[2]));

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    end
  endtask

  // Reference model: plain integer division by the mode width.
  function automatic int unsigned ny_of(input int k);
    return (k == 0) ? 8 : (k == 1) ? 7 : 9;
  endfunction
  function automatic int unsigned mn_of(input int k);
    return (k == 0) ? 17 : (k == 1) ? 15 : 19;
  endfunction
  function automatic int unsigned w_of(input int k);
    return (k == 0) ? 320 : (k == 1) ? 160 : 640;
  endfunction
  function automatic int unsigned h_of(input int k);
    return (k == 0) ? 240 : (k == 1) ? 120 : 480;
  endfunction

  task automatic model(input int k, input int unsigned a,
                       output int unsigned ex, output int unsigned ey,
                       output int unsigned ee, output int unsigned elat);
    ee = (a >= w_of(k) * h_of(k)) ? 1 : 0;
    ex = ee ? 0 : a % w_of(k);
    ey = ee ? 0 : a / w_of(k);
    elat = ee ? 1 : ny_of(k) + 1;
  endtask

  task automatic set_addr(input int k, input int unsigned a);
    case (k)
      0: a0 = a[16:0];
      1: a1 = a[14:0];
      default: a2 = a[18:0];
    endcase
  endtask

  function automatic int unsigned get_x(input int k);
    return (k == 0) ? 32'(x0) : (k == 1) ? 32'(x1) : 32'(x2);
  endfunction
  function automatic int unsigned get_y(input int k);
    return (k == 0) ? 32'(y0) : (k == 1) ? 32'(y1) : 32'(y2);
  endfunction

  // One request/response. hold = cycles of back-pressure; poke drives stray requests while busy.
  task automatic xact(input int k, input int unsigned a, input int hold, input bit poke,
                      output int unsigned xr, output int unsigned yr,
                      output int unsigned eo, output int unsigned lat);
    int n;
    set_addr(k, a);
    iv[k] = 1'b1;
    ordy[k] = 1'b0;
    n = 0;
    while (!ir[k] && n < 50) begin
      @(negedge clock);
      n++;
    end
    if (!ir[k]) check_eq("accept_timeout", 0, 1);
    @(negedge clock);
    iv[k] = poke;
    if (poke) set_addr(k, a ^ 32'h55);
    lat = 1;
    while (!ov[k] && lat < 60) begin
      if (poke) check_eq("busy_in_ready", 32'(ir[k]), 0);
      @(negedge clock);
      lat++;
    end
    if (!ov[k]) check_eq("done_timeout", 0, 1);
    xr = get_x(k);
    yr = get_y(k);
    eo = 32'(er[k]);
    for (int c = 0; c < hold; c++) begin
      @(negedge clock);
      check_eq("hold_valid", 32'(ov[k]), 1);
      check_eq("hold_x", get_x(k), xr);
      check_eq("hold_y", get_y(k), yr);
      check_eq("hold_err", 32'(er[k]), eo);
      if (poke) check_eq("hold_in_ready", 32'(ir[k]), 0);
    end
    iv[k] = 1'b0;
    ordy[k] = 1'b1;
    @(negedge clock);
    ordy[k] = 1'b0;
    check_eq("out_valid_drop", 32'(ov[k]), 0);
    check_eq("back_to_idle", 32'(ir[k]), 1);
  endtask

  task automatic run_check(input int k, input int unsigned a, input int hold, input bit poke);
    int unsigned xr, yr, eo, lat, ex, ey, ee, elat;
    model(k, a, ex, ey, ee, elat);
    xact(k, a, hold, poke, xr, yr, eo, lat);
    if (xr !== ex || yr !== ey || eo !== ee || lat !== elat)
      $display("  detail: inst %0d address %0d", k, a);
    check_eq("x", xr, ex);
    check_eq("y", yr, ey);
    check_eq("err", eo, ee);
    check_eq("latency", lat, elat);
  endtask

  task automatic sweep(input int k, input int n);
    int unsigned a, w, h, lim;
    w = w_of(k);
    h = h_of(k);
    lim = (32'd1 << mn_of(k)) - 1;
    for (int i = 0; i < n; i++) begin
      case (i % 4)
        3: a = $urandom_range(lim, 0);
        2: a = $urandom_range((w << ny_of(k)) - 1, w * h);
        default: a = $urandom_range(h - 1, 0) * w + $urandom_range(w - 1, 0);
      endcase
      run_check(k, a, 0, 1'b0);
    end
  endtask

  initial begin
    int unsigned dir_addr [7] = '{0, 319, 320, 641, 76799, 76800, 131071};
    iv = '0;
    ordy = '0;
    a0 = '0;
    a1 = '0;
    a2 = '0;
    #1;
    check_eq("rst_in_ready", 32'(ir[0]), 0);
    check_eq("rst_out_valid", 32'(ov[0]), 0);
    check_eq("rst_x", 32'(x0), 0);
    check_eq("rst_y", 32'(y0), 0);
    check_eq("rst_err", 32'(er[0]), 0);
    repeat (2) @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
    check_eq("post_rst_in_ready", 32'(ir[0]), 1);

    foreach (dir_addr[i]) run_check(0, dir_addr[i], 0, 1'b1);

    run_check(0, 1000, 20, 1'b1);

    // Abort a division part way through with reset.
    a0 = 17'd1000;
    iv[0] = 1'b1;
    @(negedge clock);
    iv[0] = 1'b0;
    repeat (4) @(negedge clock);
    check_eq("mid_div_busy", 32'(ov[0]), 0);
    reset = 1'b1;
    #1;
    check_eq("abort_out_valid", 32'(ov[0]), 0);
    check_eq("abort_x", 32'(x0), 0);
    check_eq("abort_y", 32'(y0), 0);
    check_eq("abort_err", 32'(er[0]), 0);
    check_eq("abort_in_ready", 32'(ir[0]), 0);
    @(negedge clock);
    reset = 1'b0;
    repeat (3) @(negedge clock);
    check_eq("abort_no_result", 32'(ov[0]), 0);
    check_eq("abort_ready", 32'(ir[0]), 1);
    run_check(0, 500, 0, 1'b0);

    sweep(0, 1500);
    sweep(1, 1000);
    sweep(2, 1000);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
